// File: rtl/id_ex_pipe_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register stage.
package id_ex_pipe_stage_pkg;

   // Default widths
   localparam int unsigned DefDataW   = 64;
   localparam int unsigned DefRegIdxW = 5;
   localparam int unsigned DefFunctW  = 4;
   localparam int unsigned DefCtrlW   = 8;
   localparam int unsigned DefCntW    = 16;

   // Bit positions inside the packed control bundle (CTRL_W = 8 layout)
   localparam int unsigned CtrlMemToReg = 0;
   localparam int unsigned CtrlRegWrite = 1;
   localparam int unsigned CtrlMemWrite = 2;
   localparam int unsigned CtrlMemRead  = 3;
   localparam int unsigned CtrlBranch   = 4;
   localparam int unsigned CtrlAluSrc   = 5;
   localparam int unsigned CtrlAluOpLo  = 6;
   localparam int unsigned CtrlAluOpHi  = 7;

   // Occupancy of the two-entry (head + skid) buffer
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

endpackage

// File: rtl/id_ex_pipe_stage_entry_reg.sv
// Payload register with load enable and synchronous clear; used for head and skid entries.
module id_ex_pipe_stage_entry_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q, q_d;

   // Clear wins over load; otherwise hold
   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (ld_i) begin
         q_d = d_i;
      end
   end

   // Payload storage
   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with a registered-ready skid buffer, flush and stall counter.
module id_ex_pipe_stage
   import id_ex_pipe_stage_pkg::*;
#(
   parameter int unsigned DATA_W   = DefDataW,
   parameter int unsigned REGIDX_W = DefRegIdxW,
   parameter int unsigned FUNCT_W  = DefFunctW,
   parameter int unsigned CTRL_W   = DefCtrlW,
   parameter int unsigned CNT_W    = DefCntW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [DATA_W-1:0]   in_pc_i,
   input  logic [DATA_W-1:0]   in_rs1_data_i,
   input  logic [DATA_W-1:0]   in_rs2_data_i,
   input  logic [DATA_W-1:0]   in_imm_i,
   input  logic [REGIDX_W-1:0] in_rs1_i,
   input  logic [REGIDX_W-1:0] in_rs2_i,
   input  logic [REGIDX_W-1:0] in_rd_i,
   input  logic [FUNCT_W-1:0]  in_funct_i,
   input  logic [CTRL_W-1:0]   in_ctrl_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [DATA_W-1:0]   out_pc_o,
   output logic [DATA_W-1:0]   out_rs1_data_o,
   output logic [DATA_W-1:0]   out_rs2_data_o,
   output logic [DATA_W-1:0]   out_imm_o,
   output logic [REGIDX_W-1:0] out_rs1_o,
   output logic [REGIDX_W-1:0] out_rs2_o,
   output logic [REGIDX_W-1:0] out_rd_o,
   output logic [FUNCT_W-1:0]  out_funct_o,
   output logic [CTRL_W-1:0]   out_ctrl_o,
   output logic [CNT_W-1:0]    stall_cnt_o
);

   localparam int unsigned PayloadW = 4 * DATA_W + 3 * REGIDX_W + FUNCT_W + CTRL_W;

   state_e              state_q, state_d;
   logic                accept, rel;
   logic                head_ld, skid_ld, head_from_skid;
   logic [PayloadW-1:0] in_payload, head_d, head_q, skid_q;
   logic [CTRL_W-1:0]   head_ctrl;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   assign accept = in_valid_i & in_ready_o;
   assign rel    = out_valid_o & out_ready_i;

   assign in_payload = {in_pc_i, in_rs1_data_i, in_rs2_data_i, in_imm_i,
                        in_rs1_i, in_rs2_i, in_rd_i, in_funct_i, in_ctrl_i};

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Occupancy next state; flush discards everything regardless of handshakes
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: if (accept) state_d = StOne;
            StOne: begin
               if (accept && !rel) begin
                  state_d = StFull;
               end else if (!accept && rel) begin
                  state_d = StEmpty;
               end
            end
            StFull:  if (rel) state_d = StOne;
            default: state_d = StEmpty;
         endcase
      end
   end

   // Handshake outputs decoded from the registered state only
   always_comb begin
      in_ready_o  = 1'b1;
      out_valid_o = 1'b0;
      unique case (state_q)
         StEmpty: begin
            in_ready_o  = 1'b1;
            out_valid_o = 1'b0;
         end
         StOne: begin
            in_ready_o  = 1'b1;
            out_valid_o = 1'b1;
         end
         StFull: begin
            in_ready_o  = 1'b0;
            out_valid_o = 1'b1;
         end
         default: begin
            in_ready_o  = 1'b1;
            out_valid_o = 1'b0;
         end
      endcase
   end

   // Entry load control; a flush suppresses every load so the flushed beat never lands
   always_comb begin
      head_ld        = 1'b0;
      skid_ld        = 1'b0;
      head_from_skid = 1'b0;
      if (!flush_i) begin
         unique case (state_q)
            StEmpty: head_ld = accept;
            StOne: begin
               head_ld = accept & rel;
               skid_ld = accept & ~rel;
            end
            StFull: begin
               head_ld        = rel;
               head_from_skid = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign head_d = head_from_skid ? skid_q : in_payload;

   id_ex_pipe_stage_entry_reg #(
      .WIDTH(PayloadW)
   ) u_head (
      .clk  (clk),
      .clr_i(reset),
      .ld_i (head_ld),
      .d_i  (head_d),
      .q_o  (head_q)
   );

   id_ex_pipe_stage_entry_reg #(
      .WIDTH(PayloadW)
   ) u_skid (
      .clk  (clk),
      .clr_i(reset),
      .ld_i (skid_ld),
      .d_i  (in_payload),
      .q_o  (skid_q)
   );

   assign {out_pc_o, out_rs1_data_o, out_rs2_data_o, out_imm_o,
           out_rs1_o, out_rs2_o, out_rd_o, out_funct_o, head_ctrl} = head_q;

   // Bubbles carry no control so EX cannot act on stale bits
   assign out_ctrl_o = out_valid_o ? head_ctrl : '0;

   // Saturating stall counter; flush does not touch it
   always_comb begin
      cnt_d = cnt_q;
      if (out_valid_o && !out_ready_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench: default-width instance against a queue model, plus a narrow instance.
module tb_id_ex_pipe_stage;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] rs1d;
      logic [63:0] rs2d;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  funct;
      logic [7:0]  ctrl;
   } ent_a_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  funct;
      logic [9:0]  ctrl;
   } ent_b_t;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   always #5 clk = ~clk;

   // Instance A: default parameters
   ent_a_t      a_in;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [63:0] a_out_pc, a_out_rs1d, a_out_rs2d, a_out_imm;
   logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
   logic [3:0]  a_out_funct;
   logic [7:0]  a_out_ctrl;
   logic [15:0] a_stall;
   ent_a_t      a_obs;
   assign a_obs = {a_out_pc, a_out_rs1d, a_out_rs2d, a_out_imm, a_out_rs1, a_out_rs2, a_out_rd,
                   a_out_funct, a_out_ctrl};

   // Instance B: 32-bit data, 10-bit ctrl, 4-bit stall counter
   ent_b_t      b_in;
   logic        b_flush;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_out_pc, b_out_rs1d, b_out_rs2d, b_out_imm;
   logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
   logic [3:0]  b_out_funct;
   logic [9:0]  b_out_ctrl;
   logic [3:0]  b_stall;
   ent_b_t      b_obs;
   assign b_obs = {b_out_pc, b_out_rs1d, b_out_rs2d, b_out_imm, b_out_rs1, b_out_rs2, b_out_rd,
                   b_out_funct, b_out_ctrl};

   id_ex_pipe_stage dut_a (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (flush),
      .in_valid_i    (a_in_valid),
      .in_ready_o    (a_in_ready),
      .in_pc_i       (a_in.pc),
      .in_rs1_data_i (a_in.rs1d),
      .in_rs2_data_i (a_in.rs2d),
      .in_imm_i      (a_in.imm),
      .in_rs1_i      (a_in.rs1),
      .in_rs2_i      (a_in.rs2),
      .in_rd_i       (a_in.rd),
      .in_funct_i    (a_in.funct),
      .in_ctrl_i     (a_in.ctrl),
      .out_valid_o   (a_out_valid),
      .out_ready_i   (a_out_ready),
      .out_pc_o      (a_out_pc),
      .out_rs1_data_o(a_out_rs1d),
      .out_rs2_data_o(a_out_rs2d),
      .out_imm_o     (a_out_imm),
      .out_rs1_o     (a_out_rs1),
      .out_rs2_o     (a_out_rs2),
      .out_rd_o      (a_out_rd),
      .out_funct_o   (a_out_funct),
      .out_ctrl_o    (a_out_ctrl),
      .stall_cnt_o   (a_stall)
   );

   id_ex_pipe_stage #(
      .DATA_W  (32),
      .REGIDX_W(5),
      .FUNCT_W (4),
      .CTRL_W  (10),
      .CNT_W   (4)
   ) dut_b (
      .clk           (clk),
      .reset         (reset),
      .flush_i       (b_flush),
      .in_valid_i    (b_in_valid),
      .in_ready_o    (b_in_ready),
      .in_pc_i       (b_in.pc),
      .in_rs1_data_i (b_in.rs1d),
      .in_rs2_data_i (b_in.rs2d),
      .in_imm_i      (b_in.imm),
      .in_rs1_i      (b_in.rs1),
      .in_rs2_i      (b_in.rs2),
      .in_rd_i       (b_in.rd),
      .in_funct_i    (b_in.funct),
      .in_ctrl_i     (b_in.ctrl),
      .out_valid_o   (b_out_valid),
      .out_ready_i   (b_out_ready),
      .out_pc_o      (b_out_pc),
      .out_rs1_data_o(b_out_rs1d),
      .out_rs2_data_o(b_out_rs2d),
      .out_imm_o     (b_out_imm),
      .out_rs1_o     (b_out_rs1),
      .out_rs2_o     (b_out_rs2),
      .out_rd_o      (b_out_rd),
      .out_funct_o   (b_out_funct),
      .out_ctrl_o    (b_out_ctrl),
      .stall_cnt_o   (b_stall)
   );

   // Reference model for instance A: FIFO of held entries, last head payload, stall count
   ent_a_t      mq[$];
   ent_a_t      m_last;
   int unsigned m_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic ent_a_t rand_ent_a(input logic [63:0] pc);
      ent_a_t e;
      e.pc    = pc;
      e.rs1d  = {$urandom, $urandom};
      e.rs2d  = {$urandom, $urandom};
      e.imm   = {$urandom, $urandom};
      e.rs1   = 5'($urandom);
      e.rs2   = 5'($urandom);
      e.rd    = 5'($urandom);
      e.funct = 4'($urandom);
      e.ctrl  = 8'($urandom_range(1, 255));
      return e;
   endfunction

   function automatic ent_b_t rand_ent_b(input logic [31:0] pc);
      ent_b_t e;
      e.pc    = pc;
      e.rs1d  = $urandom;
      e.rs2d  = $urandom;
      e.imm   = 32'hDEAD_BEEF;
      e.rs1   = 5'($urandom);
      e.rs2   = 5'($urandom);
      e.rd    = 5'($urandom);
      e.funct = 4'($urandom);
      e.ctrl  = 10'($urandom_range(1, 1023));
      return e;
   endfunction

   // One clock: capture pre-edge handshake view, advance model, then settle past the edge
   task automatic step();
      bit     acc, rel, stalled;
      ent_a_t inv;
      acc     = a_in_valid && (mq.size() < 2);
      rel     = (mq.size() > 0) && a_out_ready;
      stalled = (mq.size() > 0) && !a_out_ready;
      inv     = a_in;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_last = '0;
         m_cnt  = 0;
      end else begin
         if (stalled && m_cnt < 65535) m_cnt++;
         if (flush) begin
            mq.delete();
         end else begin
            if (rel) void'(mq.pop_front());
            if (acc) mq.push_back(inv);
         end
         if (mq.size() > 0) m_last = mq[0];
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 10; i++) begin
         a_in_valid  = 1'($urandom);
         a_in        = rand_ent_a(64'(i * 4));
         a_out_ready = 1'($urandom);
         b_in_valid  = 1'b1;
         b_in        = rand_ent_b(32'(i * 4));
         b_out_ready = 1'b0;
         step();
      end
      reset      = 1'b1;
      a_in_valid = 1'b1;
      a_out_ready = 1'b0;
      step();
      step();
      n_checks++;
      if (a_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %0b want 0", a_out_valid);
      end
      n_checks++;
      if (a_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %0b want 1", a_in_ready);
      end
      n_checks++;
      if (a_out_ctrl !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_out_ctrl: got %h want 00", a_out_ctrl);
      end
      n_checks++;
      if (a_stall !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_stall_cnt: got %0d want 0", a_stall);
      end
      n_checks++;
      if (a_obs !== '0) begin
         n_fail++;
         $display("FAIL reset_payload: got %h want 0", a_obs);
      end
      n_checks++;
      if (b_out_valid !== 1'b0 || b_stall !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_b: got valid=%0b stall=%0d want 0/0", b_out_valid, b_stall);
      end
      reset      = 1'b0;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      ent_a_t sent[8];
      a_out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            sent[i]    = rand_ent_a(64'(i * 4));
            a_in       = sent[i];
            a_in_valid = 1'b1;
         end else begin
            a_in_valid = 1'b0;
         end
         step();
         if (i < 8) begin
            n_checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL stream_hs[%0d]: got valid=%0b ready=%0b want 1/1", i, a_out_valid,
                        a_in_ready);
            end
            n_checks++;
            if (a_obs !== sent[i]) begin
               n_fail++;
               $display("FAIL stream_payload[%0d]: got pc=%h want pc=%h", i, a_out_pc,
                        sent[i].pc);
            end
         end else begin
            n_checks++;
            if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00) begin
               n_fail++;
               $display("FAIL stream_drain: got valid=%0b ctrl=%h want 0/00", a_out_valid,
                        a_out_ctrl);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] got[$];
      int unsigned exp_cnt;
      exp_cnt     = m_cnt + 4;
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in        = rand_ent_a(64'h0);
      step();
      a_in = rand_ent_a(64'h4);
      step();
      n_checks++;
      if (a_in_ready !== 1'b0 || a_out_pc !== 64'h0) begin
         n_fail++;
         $display("FAIL bp_full: got ready=%0b pc=%h want 0/0", a_in_ready, a_out_pc);
      end
      a_in = rand_ent_a(64'h8);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_pc !== 64'h0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got ready=%0b valid=%0b pc=%h want 0/1/0", i,
                     a_in_ready, a_out_valid, a_out_pc);
         end
      end
      a_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bit taken;
         taken = a_in_valid && a_in_ready;
         if (a_out_valid) got.push_back(a_out_pc);
         step();
         if (taken) a_in_valid = 1'b0;
      end
      n_checks++;
      if (got.size() != 3) begin
         n_fail++;
         $display("FAIL bp_count: got %0d deliveries want 3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got[i] !== 64'(i * 4)) begin
               n_fail++;
               $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 64'(i * 4));
            end
         end
      end
      n_checks++;
      if (32'(a_stall) !== exp_cnt) begin
         n_fail++;
         $display("FAIL bp_stall_cnt: got %0d want %0d", a_stall, exp_cnt);
      end
   endtask

   task automatic test_flush();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in        = rand_ent_a(64'h10);
      step();
      a_in = rand_ent_a(64'h14);
      step();
      flush = 1'b1;
      a_in  = rand_ent_a(64'h40);
      step();
      flush      = 1'b0;
      a_in_valid = 1'b0;
      n_checks++;
      if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_state: got valid=%0b ctrl=%h ready=%0b want 0/00/1", a_out_valid,
                  a_out_ctrl, a_in_ready);
      end
      n_checks++;
      if (a_out_pc !== 64'h10) begin
         n_fail++;
         $display("FAIL flush_no_capture: got pc=%h want 10", a_out_pc);
      end
      n_checks++;
      if (32'(a_stall) !== m_cnt) begin
         n_fail++;
         $display("FAIL flush_stall_cnt: got %0d want %0d", a_stall, m_cnt);
      end
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in        = rand_ent_a(64'h44);
      step();
      a_in_valid = 1'b0;
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_pc !== 64'h44) begin
         n_fail++;
         $display("FAIL flush_after: got valid=%0b pc=%h want 1/44", a_out_valid, a_out_pc);
      end
      step();
      n_checks++;
      if (a_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drain: got valid=%0b want 0", a_out_valid);
      end
   endtask

   task automatic test_random();
      ent_a_t exp;
      int     errs;
      int     i;
      errs = 0;
      for (i = 0; i < 400; i++) begin
         if (!(a_in_valid && !a_in_ready)) begin
            a_in_valid = ($urandom_range(0, 3) != 0);
            a_in       = rand_ent_a(64'(i * 4 + 64'h1000));
         end
         a_out_ready = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 19) == 0);
         step();
         exp = m_last;
         if (mq.size() == 0) exp.ctrl = '0;
         n_checks++;
         if (a_out_valid !== (mq.size() > 0) || a_in_ready !== (mq.size() < 2) ||
             a_obs !== exp || 32'(a_stall) !== m_cnt) begin
            n_fail++;
            errs++;
            if (errs < 10)
               $display("FAIL random[%0d]: got v=%0b r=%0b pc=%h c=%0d want v=%0b r=%0b pc=%h c=%0d",
                        i, a_out_valid, a_in_ready, a_out_pc, a_stall, mq.size() > 0,
                        mq.size() < 2, exp.pc, m_cnt);
         end
      end
      flush       = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      step();
      step();
   endtask

   task automatic test_saturation();
      reset = 1'b1;
      step();
      reset       = 1'b0;
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in        = rand_ent_b(32'h0);
      step();
      b_in_valid = 1'b0;
      n_checks++;
      if (b_out_valid !== 1'b1 || b_stall !== 4'd0) begin
         n_fail++;
         $display("FAIL sat_start: got valid=%0b cnt=%0d want 1/0", b_out_valid, b_stall);
      end
      repeat (5) step();
      n_checks++;
      if (b_stall !== 4'd5) begin
         n_fail++;
         $display("FAIL sat_mid: got %0d want 5", b_stall);
      end
      repeat (15) step();
      n_checks++;
      if (b_stall !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_20: got %0d want 15", b_stall);
      end
      repeat (3) step();
      b_out_ready = 1'b1;
      n_checks++;
      if (b_stall !== 4'd15) begin
         n_fail++;
         $display("FAIL sat_hold: got %0d want 15", b_stall);
      end
      step();
   endtask

   task automatic test_wide();
      ent_b_t sent[8];
      b_out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            sent[i]    = rand_ent_b(32'(i * 4));
            b_in       = sent[i];
            b_in_valid = 1'b1;
         end else begin
            b_in_valid = 1'b0;
         end
         step();
         if (i < 8) begin
            n_checks++;
            if (b_out_valid !== 1'b1 || b_in_ready !== 1'b1 || b_obs !== sent[i]) begin
               n_fail++;
               $display("FAIL wide[%0d]: got v=%0b pc=%h imm=%h ctrl=%h want 1 pc=%h imm=%h ctrl=%h",
                        i, b_out_valid, b_out_pc, b_out_imm, b_out_ctrl, sent[i].pc,
                        sent[i].imm, sent[i].ctrl);
            end
         end else begin
            n_checks++;
            if (b_out_valid !== 1'b0 || b_out_ctrl !== 10'h0) begin
               n_fail++;
               $display("FAIL wide_drain: got valid=%0b ctrl=%h want 0/000", b_out_valid,
                        b_out_ctrl);
            end
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      b_flush     = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      a_in        = '0;
      b_in_valid  = 1'b0;
      b_out_ready = 1'b0;
      b_in        = '0;
      m_last      = '0;
      m_cnt       = 0;
      step();
      step();
      reset = 1'b0;
      step();
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_random();
      test_saturation();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe_stage.md
ID_EX_PIPE_STAGE -- requirements
Module: id_ex_pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of PC, operand and immediate fields.
REQ-002 SHALL have parameter REGIDX_W, default 5, width of rs1/rs2/rd indices.
REQ-003 SHALL have parameter FUNCT_W, default 4, width of funct field.
REQ-004 SHALL have parameter CTRL_W, default 8, width of packed control bundle {ALUOp[1:0],ALUSrc,Branch,MemRead,MemWrite,RegWrite,MemToReg} at CTRL_W=8.
REQ-005 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  reset; synchronous, active-high.
REQ-008 flush  input  1  discard all held entries (branch mispredict/trap).
REQ-009 in_valid  input  1  upstream (ID) holds a valid instruction.
REQ-010 in_ready  output  1  stage can accept; registered, not combinational from out_ready.
REQ-011 in_pc, in_rs1_data, in_rs2_data, in_imm  input  DATA_W each  decoded payload.
REQ-012 in_rs1, in_rs2, in_rd  input  REGIDX_W each  register indices.
REQ-013 in_funct  input  FUNCT_W  funct bits; in_ctrl  input  CTRL_W  control bundle.
REQ-014 out_valid  output  1  head entry valid toward EX.
REQ-015 out_ready  input  1  EX accepts head entry this cycle.
REQ-016 out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd, out_funct, out_ctrl  output  widths as inputs  head entry payload.
REQ-017 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Accept when in_valid&in_ready; release when out_valid&out_ready.
REQ-019 Storage SHALL be two entries: head (main) and skid; states EMPTY (0 held), ONE (head only), FULL (head+skid).
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL.
REQ-021 EMPTY: accept -> ONE, payload into head; out_valid=1 next cycle (latency 1).
REQ-022 ONE: accept & release -> ONE, new payload into head; accept only -> FULL, payload into skid; release only -> EMPTY.
REQ-023 FULL: release -> ONE, skid moves into head same edge; no release -> FULL, all held.
REQ-024 Order SHALL be preserved; no entry dropped or duplicated absent flush.
REQ-025 flush=1 SHALL force state EMPTY next edge, overriding any simultaneous accept or release; in_ready=1 following cycle.
REQ-026 out_ctrl SHALL read all-zero whenever out_valid=0 (bubble); other out_* hold last head payload.
REQ-027 stall_cnt SHALL increment by 1 per stalled cycle, saturate at 2^CNT_W-1, unaffected by flush.
REQ-028 Full throughput: continuous in_valid with out_ready=1 SHALL pass one entry per cycle.

Reset
REQ-029 reset SHALL take priority over flush and handshakes.
REQ-030 On reset: state EMPTY, out_valid=0, in_ready=1, stall_cnt=0, all out_* payload and out_ctrl =0, skid contents =0.

Structure
REQ-031 Shared package SHALL hold ctrl bundle bit-position constants, state encoding typedef (EMPTY/ONE/FULL), and default width constants.
REQ-032 One sub-module natural: pipe_entry_reg (payload register with load enable and synchronous clear), instantiated for head and skid.

Verification
REQ-033 Reset: assert reset 2 cycles mid-traffic -> out_valid=0, in_ready=1, out_ctrl=0x00, stall_cnt=0.
REQ-034 Streaming: 8 back-to-back entries pc=0x0,0x4..0x1C, out_ready=1 -> out_pc 0x0..0x1C in order, 1-cycle latency, no gaps.
REQ-035 Backpressure: out_ready=0 after pc=0x0 accepted, send 0x4,0x8 -> in_ready=0 after 0x4 captured, 0x8 held upstream; out_ready=1 -> 0x0,0x4,0x8 delivered in order; stall_cnt counts stalled cycles exactly.
REQ-036 Flush in FULL with simultaneous in_valid (pc=0x40) -> next cycle out_valid=0, out_ctrl=0x00, 0x40 not captured; later entry pc=0x44 delivered normally.
REQ-037 Saturation: CNT_W=4, hold stall 20 cycles -> stall_cnt=15, stays 15.
REQ-038 Parameter sweep: DATA_W=32, REGIDX_W=5, CTRL_W=10 -> REQ-034 passes with full-width payload integrity (in_imm=0xDEADBEEF).
